mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 4 +
 rtl/mem_arbiter.sv | 46 ++++
 tb/tb_mem_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding for the instruction/data memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, RSP_I, RSP_D} arbState_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between fetch and data requesters
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);
  arbState_t state, nextState;
  logic grantD, grantI;
  logic unusedAddr;
  assign unusedAddr = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};
  // The requester whose response is due is never re-granted, which yields D,I alternation
  always_comb begin
    grantD    = n_reset && d_req && state != RSP_D;
    grantI    = n_reset && i_req && state != RSP_I && !grantD;
    nextState = grantD ? RSP_D : grantI ? RSP_I : IDLE;
    m_en      = grantD || grantI;
    m_we      = grantD && d_we;
    m_addr    = grantD ? d_addr[ADDR_W+1:2] : grantI ? i_addr[ADDR_W+1:2] : '0;
    m_wdata   = grantD ? d_wdata : '0;
  end
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) state <= IDLE;
    else state <= nextState;
  assign i_ready = state == RSP_I;
  assign d_ready = state == RSP_D;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed test of mem_arbiter against a request/response model and a memory model
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;
  logic clk = 0, n_reset = 0;
  logic i_req = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic [31:0] i_rdata, d_rdata, m_wdata, m_rdata;
  logic i_ready, d_ready, m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [31:0] mem [DEPTH];
  logic [31:0] shadow [DEPTH];
  int pend = 0;
  logic pendWe = 0;
  logic [31:0] pendData = 0;
  int nChecks = 0, nFail = 0;

  mem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .n_reset(n_reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int wordOf(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // Who is served this cycle: 0 nobody, 1 fetch, 2 data; a requester waiting on its own response is skipped
  function automatic int expGrant();
    if (!n_reset) return 0;
    if (d_req && pend != 2) return 2;
    if (i_req && pend != 1) return 1;
    return 0;
  endfunction

  // Synchronous memory driven by the DUT's strobes
  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr] <= m_wdata;
    if (m_en) m_rdata <= mem[m_addr];
  end

  // Model: remembers which response is owed and what data it must carry
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) pend <= 0;
    else begin
      pend <= expGrant();
      pendWe <= expGrant() == 2 && d_we;
      if (expGrant() == 2) pendData <= shadow[wordOf(d_addr)];
      if (expGrant() == 1) pendData <= shadow[wordOf(i_addr)];
      if (expGrant() == 2 && d_we) shadow[wordOf(d_addr)] <= d_wdata;
    end
  end

  always @(negedge clk) begin
    int g;
    g = expGrant();
    chk("m_en", 32'(m_en), 32'(g != 0));
    chk("m_we", 32'(m_we), 32'(g == 2 && d_we));
    chk("m_addr", 32'(m_addr), g == 2 ? wordOf(d_addr) : g == 1 ? wordOf(i_addr) : 0);
    chk("m_wdata", m_wdata, g == 2 ? d_wdata : 32'h0);
    chk("i_ready", 32'(i_ready), 32'(pend == 1));
    chk("d_ready", 32'(d_ready), 32'(pend == 2));
    if (pend == 1) chk("i_rdata", i_rdata, pendData);
    if (pend == 2 && !pendWe) chk("d_rdata", d_rdata, pendData);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] seq;
    int iR, dR;
    for (int k = 0; k < DEPTH; k++) begin
      mem[k] = 32'h5A000000 + k;
      shadow[k] = 32'h5A000000 + k;
    end
    mem[0] = 32'hAA; shadow[0] = 32'hAA;
    mem[1] = 32'h13; shadow[1] = 32'h13;
    mem[2] = 32'h22; shadow[2] = 32'h22;
    @(negedge clk);
    chk("rst m_en", 32'(m_en), 0);
    chk("rst i_ready", 32'(i_ready), 0);
    chk("rst d_ready", 32'(d_ready), 0);
    step();
    n_reset = 1;
    // fetch
    i_req = 1; i_addr = 32'h4;
    @(negedge clk);
    chk("fetch m_en", 32'(m_en), 1);
    chk("fetch m_we", 32'(m_we), 0);
    chk("fetch m_addr", 32'(m_addr), 1);
    step();
    @(negedge clk);
    chk("fetch i_ready", 32'(i_ready), 1);
    chk("fetch i_rdata", i_rdata, 32'h13);
    step();
    i_req = 0;
    // store
    d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'h1FE;
    @(negedge clk);
    chk("store m_we", 32'(m_we), 1);
    chk("store m_addr", 32'(m_addr), 4);
    chk("store m_wdata", m_wdata, 32'h1FE);
    step();
    @(negedge clk);
    chk("store d_ready", 32'(d_ready), 1);
    step();
    d_req = 0; d_we = 0;
    // simultaneous
    i_req = 1; i_addr = 32'h8; d_req = 1; d_addr = 32'h0;
    @(negedge clk);
    chk("sim c0 m_addr", 32'(m_addr), 0);
    step();
    @(negedge clk);
    chk("sim c1 m_addr", 32'(m_addr), 2);
    chk("sim c1 d_ready", 32'(d_ready), 1);
    chk("sim c1 d_rdata", d_rdata, 32'hAA);
    step();
    d_req = 0;
    @(negedge clk);
    chk("sim c2 i_ready", 32'(i_ready), 1);
    chk("sim c2 i_rdata", i_rdata, 32'h22);
    step();
    i_req = 0;
    // alternation
    i_req = 1; i_addr = 32'h20; d_req = 1; d_addr = 32'h30;
    seq = '0; iR = 0; dR = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seq[5-c] = m_en && m_addr == 12;
      iR += int'(i_ready);
      dR += int'(d_ready);
      step();
    end
    i_req = 0; d_req = 0;
    @(negedge clk);
    iR += int'(i_ready);
    dR += int'(d_ready);
    chk("alt grant order", 32'(seq), 32'b101010);
    chk("alt i pulses", 32'(iR), 3);
    chk("alt d pulses", 32'(dR), 3);
    step();
    // address slicing
    d_req = 1; d_addr = 32'h13;
    @(negedge clk);
    chk("slice d m_addr", 32'(m_addr), 4);
    step();
    d_req = 0; i_req = 1; i_addr = 32'h1004;
    @(negedge clk);
    chk("slice i m_addr", 32'(m_addr), 1);
    step();
    i_req = 0;
    step();
    // reset while a data response is owed
    d_req = 1; d_addr = 32'h10;
    step();
    #2 n_reset = 0;
    #1;
    chk("rst mid d_ready", 32'(d_ready), 0);
    chk("rst mid m_en", 32'(m_en), 0);
    d_req = 0;
    step();
    n_reset = 1;
    step();
    d_req = 1; d_addr = 32'h10;
    @(negedge clk);
    chk("post-rst m_en", 32'(m_en), 1);
    chk("post-rst m_addr", 32'(m_addr), 4);
    step();
    @(negedge clk);
    chk("post-rst d_ready", 32'(d_ready), 1);
    chk("post-rst d_rdata", d_rdata, 32'h1FE);
    step();
    d_req = 0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
